// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// riscv_ctrl_pkg : shared types and constants for the multicycle controller
// Optional: MC_ILLEGAL_TRAP_EN adds the TRAP state.      Revision: 1.0
// ============================================================================
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
`ifdef MC_ILLEGAL_TRAP_EN
        BEQ      = 4'd10,
        TRAP     = 4'd11
`else
        BEQ      = 4'd10
`endif
    } mc_state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore output table; anything not set stays zero (TRAP included).
    function automatic ctrl_t state_ctrl(input mc_state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.pc_update  = 1'b1;
            end
            DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            MEMREAD:  c.adr_src = 1'b1;
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = ALUOP_FUNCT;
            end
            EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALUOP_FUNCT;
            end
            ALUWB:    c.reg_write = 1'b1;
            JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aludecoder.sv
`default_nettype none
// ============================================================================
// aludecoder : maps ALUOp and instruction funct fields to the ALU function
// Revision: 1.0
// ============================================================================
module aludecoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    // Only R-type (op5=1) with funct7b5 subtracts; addi never does.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/main_fsm.sv
`default_nettype none
// ============================================================================
// main_fsm : multicycle sequencing FSM with registered Moore outputs
// Optional: MC_ILLEGAL_TRAP_EN traps unknown opcodes.     Revision: 1.0
// ============================================================================
module main_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    output ctrl_t      ctrl,
    output logic       illegal_instr
);

    mc_state_t state_q, state_d;
    ctrl_t     ctrl_q, ctrl_d;
`ifdef MC_ILLEGAL_TRAP_EN
    logic      illegal_q, illegal_d;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = TRAP;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            JAL:      state_d = ALUWB;
            BEQ:      state_d = FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            TRAP:     state_d = TRAP;
`endif
            default:  state_d = FETCH;
        endcase

        // Outputs registered from the next state equal Moore outputs of state_q.
        ctrl_d = state_ctrl(state_d);
`ifdef MC_ILLEGAL_TRAP_EN
        illegal_d = illegal_q | (state_d == TRAP);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            ctrl_q    <= state_ctrl(FETCH);
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign ctrl = ctrl_q;
`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_instr = illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// multicycle_controller : control unit for the multicycle RV32I datapath
// Optional: MC_ILLEGAL_TRAP_EN (sticky illegal-opcode trap). Revision: 1.0
// ============================================================================
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic       illegal_instr
);

    ctrl_t w_ctrl;

    main_fsm u_main_fsm (
        .clk           (clk),
        .reset_n       (reset_n),
        .op            (op),
        .ctrl          (w_ctrl),
        .illegal_instr (illegal_instr)
    );

    aludecoder u_aludecoder (
        .alu_op      (w_ctrl.alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

    assign pc_write   = w_ctrl.pc_update | (w_ctrl.branch & zero);
    assign adr_src    = w_ctrl.adr_src;
    assign mem_write  = w_ctrl.mem_write;
    assign ir_write   = w_ctrl.ir_write;
    assign result_src = w_ctrl.result_src;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign reg_write  = w_ctrl.reg_write;

    always_comb begin
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RISC-V (RV32I subset) processor: a Moore main FSM that sequences the shared ALU, register file, instruction/data memory port and PC across 3–5 cycles per instruction. It receives the opcode, funct fields and ALU Zero flag from the datapath. It drives every datapath enable and mux select. ALU function selection is delegated to the existing `aludecoder`, driven by an FSM-generated ALUOp.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 7: instr[6:0].
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU result == 0, combinational from the datapath.
- `pc_write` out 1: load PC.
- `adr_src` out 1: memory address select; 0 = PC, 1 = result.
- `mem_write` out 1: store enable.
- `ir_write` out 1: load instruction register and OldPC.
- `result_src` out 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a` out 2: 00 = PC, 01 = OldPC, 10 = rs1 data.
- `alu_src_b` out 2: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- `imm_src` out 2: 00 = I, 01 = S, 10 = B, 11 = J.
- `reg_write` out 1: register file write enable.
- `alu_control` out 3: from `aludecoder`; 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `illegal_instr` out 1: sticky illegal-opcode flag; see Configuration.

## Operation
States are 4-bit. Outputs not listed for a state are 0 / 00. ALUOp: 00 = add, 01 = sub, 10 = decode funct.

- FETCH: ir_write=1, alu_src_b=10, result_src=10, pc_update=1, ALUOp=00. Next: DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, ALUOp=00. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other → see Configuration
- MEMADR: alu_src_a=10, alu_src_b=01. Next: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: adr_src=1, mem_write=1. Next: FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, ALUOp=10. Next: ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, ALUOp=10. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_update=1. Next: ALUWB.
- BEQ: alu_src_a=10, alu_src_b=00, ALUOp=01, branch=1. Next: FETCH.

Combinational signals:
- pc_write = pc_update | (branch & zero).
- imm_src from op alone, in every state: 0100011→01, 1100011→10, 1101111→11, all other ops→00.
- `aludecoder` inputs: ALUOp, funct3, op[5], funct7b5.

## Timing
- Moore FSM. All outputs are combinational from the state register, except pc_write (depends on zero) and imm_src / alu_control (depend on op/funct).
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, I-type ALU 4, jal 4, beq 3.
- Reset (reset_n=0, asynchronous): state=FETCH and illegal_instr=0.
  - While in reset, outputs show FETCH values: ir_write=1, pc_write=1, alu_src_b=10, result_src=10, all others 0.
  - Datapath registers are held by their own reset.
- Reset asserted mid-instruction aborts it immediately. No partial write is completed after the assertion edge.
- First rising edge after reset_n deasserts performs the first fetch.
- zero is sampled combinationally only in BEQ; no registered branch decision.

## Configuration
`MC_ILLEGAL_TRAP_EN`:
- Defined:
  - Unknown op in DECODE → TRAP state. TRAP holds all enables at 0 and self-loops until reset.
  - illegal_instr sets on entry to TRAP and stays 1 until reset.
- Undefined:
  - Unknown op in DECODE → FETCH; the instruction retires as a 2-cycle no-op.
  - illegal_instr is tied to 0. TRAP encoding does not exist.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - state enum `mc_state_t`: FETCH=0 … BEQ=10, TRAP=11
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ
  - ALUOp constants: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - ImmSrc constants
- Sub-module `main_fsm` contains:
  - state register and next-state logic
  - per-state outputs, including pc_update, branch, ALUOp
- Top instantiates `main_fsm` and `aludecoder`, and adds the pc_write and imm_src logic.

## Test plan
- Reset: reset_n=0 mid-MEMREAD → state FETCH immediately, ir_write=1, reg_write=0, mem_write=0. Release → DECODE after one edge.
- lw (op=0000011):
  - Visits FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - reg_write=1 only in cycle 5, with result_src=01.
  - alu_control=000 throughout.
- R-type sub (op=0110011, funct3=000, funct7b5=1) → EXECR asserts alu_control=001. ALUWB follows, then FETCH. Total 4 cycles.
- I-type addi with funct7b5=1 (op=0010011, funct3=000) → alu_control=000, no subtract because op[5]=0. Same case with funct3=110 → alu_control=011.
- beq (op=1100011):
  - zero=1 → pc_write=1 in BEQ, alu_control=001, imm_src=10.
  - zero=0 → pc_write=0.
  - Both cases return to FETCH after 3 cycles.
- Unknown op 1111111:
  - With `MC_ILLEGAL_TRAP_EN`: TRAP, illegal_instr=1, all writes 0 for 10+ cycles until reset.
  - Without the macro: back to FETCH after DECODE, illegal_instr=0.
